// File: rtl/writeback_unit_if.sv
// Writeback bus: groups the execute-side request, the data memory response,
// the register-file write port and the status outputs of writeback_unit.
//   master : execute / memory / register-file side (drives requests and
//            memory responses, observes the write port and status)
//   slave  : writeback_unit itself
interface writeback_unit_if #(
  parameter int WORD_SIZE = 32,
  parameter int RETIRE_W  = 32,
  parameter int LSB_W     = $clog2(WORD_SIZE/8)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           wb_sel;
  logic [WORD_SIZE-1:0] alu_result;
  logic [WORD_SIZE-1:0] pc_plus4;
  logic [WORD_SIZE-1:0] imm;
  logic [1:0]           load_size;
  logic                 load_unsigned;
  logic [LSB_W-1:0]     addr_low;
  logic [4:0]           reg_dest_in;
  logic                 write_enable_in;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_rvalid;
  logic                 flush;
  logic [WORD_SIZE-1:0] write_data;
  logic [4:0]           write_addr;
  logic                 write_enable_out;
  logic                 busy;
  logic [RETIRE_W-1:0]  retire_count;

  modport master (
    output in_valid, wb_sel, alu_result, pc_plus4, imm, load_size,
           load_unsigned, addr_low, reg_dest_in, write_enable_in,
           mem_rdata, mem_rvalid, flush,
    input  in_ready, write_data, write_addr, write_enable_out, busy,
           retire_count
  );

  modport slave (
    input  in_valid, wb_sel, alu_result, pc_plus4, imm, load_size,
           load_unsigned, addr_low, reg_dest_in, write_enable_in,
           mem_rdata, mem_rvalid, flush,
    output in_ready, write_data, write_addr, write_enable_out, busy,
           retire_count
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: selects the writeback source (ALU, load, PC+4, immediate),
// aligns and extends load data, and drives one registered register-file
// write port. Loads park in WAIT_LOAD until the memory response arrives.
// Ports:
//   clock   rising-edge clock
//   reset_n synchronous active-low reset
//   bus     writeback_unit_if.slave (request, memory response, write port,
//           busy and retire_count status)
module writeback_unit #(
  parameter int WORD_SIZE = 32,
  parameter int RETIRE_W  = 32,
  parameter int LSB_W     = $clog2(WORD_SIZE/8)
) (
  input  logic             clock,
  input  logic             reset_n,
  writeback_unit_if.slave  bus
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;

  state_t               state;
  logic [WORD_SIZE-1:0] wr_data_p1;
  logic [4:0]           wr_addr_p1;
  logic                 vld_p1;
  logic [RETIRE_W-1:0]  retire_p1;

  logic [4:0]           pend_rd;
  logic                 pend_we;
  logic [1:0]           pend_size;
  logic                 pend_uns;
  logic [LSB_W-1:0]     pend_off;

  logic                 accept;
  logic [WORD_SIZE-1:0] src_data;

  // Shift the addressed field down to bit 0, then sign- or zero-extend it.
  // Offsets are forced to the natural alignment of the access size; double
  // (and word at 32 bits, where the offset mask leaves zero) takes the
  // whole response word.
  function automatic logic [WORD_SIZE-1:0] align_extend(
    input logic [WORD_SIZE-1:0] rdata,
    input logic [1:0]           size,
    input logic                 uns,
    input logic [LSB_W-1:0]     off
  );
    logic [LSB_W-1:0]     o;
    logic [WORD_SIZE-1:0] shifted;
    logic [WORD_SIZE-1:0] res;
    logic signed [7:0]    b;
    logic signed [15:0]   h;
    logic signed [31:0]   w;
    case (size)
      2'd0:    o = off;
      2'd1:    o = off & ~LSB_W'(1);
      2'd2:    o = off & ~LSB_W'(3);
      default: o = '0;
    endcase
    shifted = rdata >> {o, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    w = shifted[31:0];
    case (size)
      2'd0:    res = uns ? WORD_SIZE'(shifted[7:0])  : WORD_SIZE'(b);
      2'd1:    res = uns ? WORD_SIZE'(shifted[15:0]) : WORD_SIZE'(h);
      2'd2:    res = uns ? WORD_SIZE'(shifted[31:0]) : WORD_SIZE'(w);
      default: res = (WORD_SIZE == 64) ? shifted
                     : (uns ? WORD_SIZE'(shifted[31:0]) : WORD_SIZE'(w));
    endcase
    return res;
  endfunction

  assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

  always_comb begin
    case (bus.wb_sel)
      SEL_ALU: src_data = bus.alu_result;
      SEL_PC4: src_data = bus.pc_plus4;
      2'd3:    src_data = bus.imm;
      default: src_data = bus.alu_result;
    endcase
  end

  // ---- p0 -> p1: write port, retirement and load-wait state ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_data_p1 <= '0;
      wr_addr_p1 <= '0;
      vld_p1     <= 1'b0;
      retire_p1  <= '0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.wb_sel == SEL_LOAD) begin
              state <= WAIT_LOAD;
            end else begin
              wr_data_p1 <= src_data;
              wr_addr_p1 <= bus.reg_dest_in;
              vld_p1     <= bus.write_enable_in && (bus.reg_dest_in != 5'd0);
              retire_p1  <= retire_p1 + 1'b1;
            end
          end
        end
        WAIT_LOAD: begin
          // flush wins over a same-cycle response: the load is dropped.
          if (bus.flush) begin
            state <= IDLE;
          end else if (bus.mem_rvalid) begin
            wr_data_p1 <= align_extend(bus.mem_rdata, pend_size, pend_uns, pend_off);
            wr_addr_p1 <= pend_rd;
            vld_p1     <= pend_we && (pend_rd != 5'd0);
            retire_p1  <= retire_p1 + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load attributes captured at accept; only meaningful in WAIT_LOAD.
  always_ff @(posedge clock) begin
    if (accept && (bus.wb_sel == SEL_LOAD)) begin
      pend_rd   <= bus.reg_dest_in;
      pend_we   <= bus.write_enable_in;
      pend_size <= bus.load_size;
      pend_uns  <= bus.load_unsigned;
      pend_off  <= bus.addr_low;
    end
  end

  assign bus.in_ready         = (state == IDLE) && !bus.flush;
  assign bus.busy             = (state == WAIT_LOAD);
  assign bus.write_data       = wr_data_p1;
  assign bus.write_addr       = wr_addr_p1;
  assign bus.write_enable_out = vld_p1;
  assign bus.retire_count     = retire_p1;

endmodule
